// File: rtl/mult_sequencer_if.sv
// Handshake and shared-ALU port bundle between the execute stage and mult_sequencer.
// master drives requests and ALU results; slave is the sequencer itself.
interface mult_sequencer_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [3:0]           alu_operation;
   logic [WIDTH-1:0]     alu_a;
   logic [WIDTH-1:0]     alu_b;
   logic [WIDTH-1:0]     alu_result;
   logic                 alu_zero;

   modport master (
      output start, mcand, mplier, alu_result, alu_zero,
      input  busy, done, product, alu_operation, alu_a, alu_b
   );

   modport slave (
      input  start, mcand, mplier, alu_result, alu_zero,
      output busy, done, product, alu_operation, alu_a, alu_b
   );
endinterface

// File: rtl/mult_sequencer.sv
// Unsigned 32x32->64 shift-add multiplier that borrows the shared ALU for every add and
// carry detect; 33+2*popcount(mplier) cycles per product, start ignored while busy.
module mult_sequencer #(
   parameter int         WIDTH  = 32,
   parameter logic [3:0] OP_ADD = 4'b0010,
   parameter logic [3:0] OP_SLT = 4'b0111
) (
   input logic              clk,
   input logic              reset,
   mult_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD,
      S_CARRY,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mc_q, mc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [WIDTH-1:0]     sum_q, sum_d;
   logic                 c_q, c_d;
   logic [4:0]           count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [3:0]           alu_op;
   logic [WIDTH-1:0]     alu_a, alu_b;

   // The zero flag carries no information this sequencer needs.
   logic unused_alu_zero;
   assign unused_alu_zero = bus.alu_zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mc_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         sum_q     <= '0;
         c_q       <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mc_q      <= mc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         sum_q     <= sum_d;
         c_q       <= c_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mc_d      = mc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      sum_d     = sum_q;
      c_d       = c_q;
      count_d   = count_q;
      product_d = product_q;
      alu_op    = OP_ADD;
      alu_a     = '0;
      alu_b     = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mc_d      = bus.mcand;
               hi_d      = '0;
               lo_d      = bus.mplier;
               c_d       = 1'b0;
               count_d   = '0;
               product_d = '0;
               state_d   = bus.mplier[0] ? S_ADD : S_SHIFT;
            end
         end
         S_ADD: begin
            alu_op  = OP_ADD;
            alu_a   = hi_q;
            alu_b   = mc_q;
            sum_d   = bus.alu_result;
            state_d = S_CARRY;
         end
         S_CARRY: begin
            // A wrapped add leaves the sum below the old high word.
            alu_op  = OP_SLT;
            alu_a   = sum_q;
            alu_b   = hi_q;
            c_d     = bus.alu_result[0];
            hi_d    = sum_q;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            {c_d, hi_d, lo_d} = {1'b0, c_q, hi_q, lo_q[WIDTH-1:1]};
            if (count_q == 5'(WIDTH - 1)) begin
               product_d = {hi_d, lo_d};
               state_d   = S_DONE;
            end else begin
               count_d = count_q + 5'd1;
               state_d = lo_q[1] ? S_ADD : S_SHIFT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = (state_q == S_DONE);
   assign bus.product       = product_q;
   assign bus.alu_operation = alu_op;
   assign bus.alu_a         = alu_a;
   assign bus.alu_b         = alu_b;
endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: a combinational ALU stand-in, a transaction-level model of
// product and latency checked every cycle, and directed plus random runs.
module tb_mult_sequencer;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLT = 4'b0111;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_sequencer_if #(.WIDTH(32)) bus ();

   mult_sequencer #(.WIDTH(32), .OP_ADD(OP_ADD), .OP_SLT(OP_SLT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   assign bus.alu_result = (bus.alu_operation == OP_ADD) ? bus.alu_a + bus.alu_b :
                           (bus.alu_operation == OP_SLT) ? {31'b0, (bus.alu_a < bus.alu_b)} :
                           32'h0;
   assign bus.alu_zero   = (bus.alu_result == 32'h0);

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Transaction-level model: idle / running / done, with the run length taken from popcount.
   typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
   mph_t        mph     = M_IDLE;
   bit          m_valid = 1'b0;
   int          m_cnt, m_lat;
   logic [63:0] m_prod  = 64'h0;
   logic [63:0] m_final = 64'h0;
   logic [31:0] m_mp    = 32'h0;
   int          slt_cnt   = 0;
   int          carry1_cnt = 0;

   always @(negedge clk) begin
      if (m_valid) begin
         case (mph)
            M_IDLE: begin
               chk("idle_busy", 64'(bus.busy), 64'd0);
               chk("idle_done", 64'(bus.done), 64'd0);
               chk("idle_product", bus.product, m_prod);
               chk("idle_alu_op", 64'(bus.alu_operation), 64'(OP_ADD));
               chk("idle_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
            end
            M_RUN: begin
               chk("run_busy", 64'(bus.busy), 64'd1);
               chk("run_done", 64'(bus.done), 64'd0);
               chk("run_product", bus.product, m_prod);
               if (bus.alu_operation == OP_SLT) begin
                  slt_cnt++;
                  if (bus.alu_result[0]) carry1_cnt++;
               end
            end
            M_DONE: begin
               chk("done_busy", 64'(bus.busy), 64'd1);
               chk("done_flag", 64'(bus.done), 64'd1);
               chk("done_product", bus.product, m_final);
               chk("done_alu_op", 64'(bus.alu_operation), 64'(OP_ADD));
               chk("slt_cycles", 64'(slt_cnt), 64'($countones(m_mp)));
            end
            default: ;
         endcase
      end
      if (reset) begin
         mph     = M_IDLE;
         m_prod  = 64'h0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         case (mph)
            M_IDLE: if (bus.start) begin
               mph        = M_RUN;
               m_cnt      = 0;
               m_mp       = bus.mplier;
               m_final    = 64'(bus.mcand) * 64'(bus.mplier);
               m_lat      = 33 + 2 * $countones(bus.mplier);
               m_prod     = 64'h0;
               slt_cnt    = 0;
               carry1_cnt = 0;
            end
            M_RUN: begin
               m_cnt++;
               if (m_cnt == m_lat - 1) begin
                  mph    = M_DONE;
                  m_prod = m_final;
               end
            end
            M_DONE: mph = M_IDLE;
            default: mph = M_IDLE;
         endcase
      end
   end

   // Launches one run; returns at the negedge of the done cycle with the measured latency
   // (edges from acceptance to the edge that samples done high).
   task automatic do_run(input logic [31:0] mc, input logic [31:0] mp,
                         output int lat, output logic [63:0] prod);
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.mcand  = mc;
      bus.mplier = mp;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.mcand  = $urandom;
      bus.mplier = $urandom;
      lat  = -1;
      prod = 64'h0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (bus.done) begin
            lat  = k;
            prod = bus.product;
            break;
         end
      end
      if (lat < 0) chk("run_timeout", 64'd0, 64'd1);
   endtask

   int          lat;
   logic [63:0] prod;
   logic [31:0] ra, rb;

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.mcand  = 32'h0;
      bus.mplier = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_product", bus.product, 64'd0);
      chk("rst_alu_op", 64'(bus.alu_operation), 64'h2);
      chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      do_run(32'd3, 32'd5, lat, prod);
      chk("t1_product", prod, 64'h0000_0000_0000_000F);
      chk("t1_latency", 64'(lat), 64'd37);
      @(negedge clk);
      chk("t1_done_one_cycle", 64'(bus.done), 64'd0);
      chk("t1_busy_fall", 64'(bus.busy), 64'd0);

      do_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, prod);
      chk("t2_product", prod, 64'hFFFF_FFFE_0000_0001);
      chk("t2_latency", 64'(lat), 64'd97);
      chk("t2_carry_seen", 64'(carry1_cnt > 0), 64'd1);

      do_run(32'hDEAD_BEEF, 32'h0, lat, prod);
      chk("t3_product", prod, 64'd0);
      chk("t3_latency", 64'(lat), 64'd33);
      chk("t3_no_slt", 64'(slt_cnt), 64'd0);

      fork
         do_run(32'h0000_1234, 32'h0000_0010, lat, prod);
         begin
            repeat (10) @(posedge clk);
            #1;
            bus.start  = 1'b1;
            bus.mcand  = 32'hAAAA_5555;
            bus.mplier = 32'h0F0F_0F0F;
            @(posedge clk); #1;
            bus.start  = 1'b0;
         end
      join
      chk("t4_product", prod, 64'h0000_0000_0001_2340);
      chk("t4_latency", 64'(lat), 64'd35);
      do_run(32'h0000_FFFF, 32'h0000_FFFF, lat, prod);
      chk("t4b_product", prod, 64'h0000_0000_FFFE_0001);
      chk("t4b_latency", 64'(lat), 64'd65);

      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.mcand  = 32'hFFFF_FFFF;
      bus.mplier = 32'h1234_5678;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      reset      = 1'b1;
      bus.start  = 1'b1;
      bus.mcand  = 32'd9;
      bus.mplier = 32'd9;
      @(posedge clk); #1;
      reset     = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("t5_busy", 64'(bus.busy), 64'd0);
      chk("t5_done", 64'(bus.done), 64'd0);
      chk("t5_product", bus.product, 64'd0);
      do_run(32'd7, 32'd6, lat, prod);
      chk("t5_product_42", prod, 64'd42);
      chk("t5_latency", 64'(lat), 64'd37);

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 10 == 0) rb = rb & $urandom;
         do_run(ra, rb, lat, prod);
         chk("rnd_product", prod, 64'(ra) * 64'(rb));
         chk("rnd_latency", 64'(lat), 64'(33 + 2 * $countones(rb)));
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
